// File: rtl/instr_decode_stage.sv
// Registered, handshaked instruction-decode stage: assembles opcode + immediate
// bytes from the program-memory stream and emits one decoded record per instruction.
module instr_decode_stage #(
  parameter int unsigned IMM_BYTES = 1,
  parameter int unsigned DROP_NOOP = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [22:0]            out_dec,
  output logic [3:0]             out_field,
  output logic [8*IMM_BYTES-1:0] out_imm,
  output logic                   out_has_imm,
  output logic [CNT_W-1:0]       instr_cnt
);

  localparam int unsigned IMM_W = 8 * IMM_BYTES;
  localparam logic [1:0]  LAST_K = 2'(IMM_BYTES - 1);

  typedef enum logic {
    S_OPC,
    S_IMM
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]       r_bcnt;
  logic [22:0]      r_pend_dec;
  logic [3:0]       r_pend_field;
  logic [IMM_W-1:0] r_acc;

  logic             r_out_valid;
  logic [22:0]      r_out_dec;
  logic [3:0]       r_out_field;
  logic [IMM_W-1:0] r_out_imm;
  logic             r_out_has_imm;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_is_imm;
  logic             w_is_noop;
  logic             w_last;
  logic [22:0]      w_opc_dec;
  logic [IMM_W-1:0] w_imm_merged;

  logic             w_load;
  logic [22:0]      w_ld_dec;
  logic [3:0]       w_ld_field;
  logic [IMM_W-1:0] w_ld_imm;
  logic             w_ld_has;
  logic             w_start_imm;

  function automatic logic [22:0] f_decode(input logic [7:0] opc);
    logic [4:0] idx;
    case (opc[7:4])
      4'h0:    idx = 5'd0;
      4'h1:    idx = 5'd1 + {3'b000, opc[1:0]};
      4'h2:    idx = 5'd5;
      4'h3:    idx = 5'd6;
      4'h4:    idx = 5'd7;
      4'h5:    idx = 5'd8;
      4'h6:    idx = 5'd9;
      4'h7:    idx = 5'd10;
      4'h8:    idx = 5'd11;
      4'h9:    idx = 5'd12;
      4'hA:    idx = 5'd13;
      4'hB:    idx = 5'd14;
      4'hC:    idx = 5'd15 + {4'b0000, opc[0]};
      4'hD:    idx = 5'd17;
      4'hE:    idx = 5'd18;
      default: idx = 5'd19 + {3'b000, opc[1:0]};
    endcase
    return 23'(1) << idx;
  endfunction

  function automatic logic f_imm_class(input logic [3:0] hi);
    return (hi == 4'h3) || (hi == 4'h5) || (hi == 4'h7) ||
           (hi == 4'hE) || (hi == 4'hF);
  endfunction

  assign w_in_ready = rst_n && !flush && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_is_imm   = f_imm_class(in_data[7:4]);
  assign w_is_noop  = (in_data[7:4] == 4'h0);
  assign w_last     = (r_bcnt == LAST_K);
  assign w_opc_dec  = f_decode(in_data);

  // Partial immediate with the incoming byte dropped into lane r_bcnt.
  always_comb begin
    w_imm_merged = r_acc;
    for (int unsigned k = 0; k < IMM_BYTES; k++) begin
      if (r_bcnt == 2'(k)) begin
        w_imm_merged[8*k +: 8] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OPC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_OPC;
    end else if (w_in_fire) begin
      case (r_state)
        S_OPC:   if (w_is_imm) w_state_nxt = S_IMM;
        S_IMM:   if (w_last)   w_state_nxt = S_OPC;
        default: w_state_nxt = S_OPC;
      endcase
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_ld_dec    = '0;
    w_ld_field  = '0;
    w_ld_imm    = '0;
    w_ld_has    = 1'b0;
    w_start_imm = 1'b0;
    if (w_in_fire) begin
      if (r_state == S_OPC) begin
        if (w_is_imm) begin
          w_start_imm = 1'b1;
        end else if (!((DROP_NOOP != 0) && w_is_noop)) begin
          w_load     = 1'b1;
          w_ld_dec   = w_opc_dec;
          w_ld_field = in_data[3:0];
        end
      end else if (w_last) begin
        w_load     = 1'b1;
        w_ld_dec   = r_pend_dec;
        w_ld_field = r_pend_field;
        w_ld_imm   = w_imm_merged;
        w_ld_has   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt       <= '0;
      r_pend_dec   <= '0;
      r_pend_field <= '0;
      r_acc        <= '0;
    end else if (flush) begin
      r_bcnt <= '0;
    end else if (w_start_imm) begin
      r_bcnt       <= '0;
      r_pend_dec   <= w_opc_dec;
      r_pend_field <= in_data[3:0];
      r_acc        <= '0;
    end else if (w_in_fire && (r_state == S_IMM)) begin
      r_bcnt <= w_last ? 2'd0 : r_bcnt + 2'd1;
      r_acc  <= w_imm_merged;
    end
  end

  // flush never coincides with w_load because in_ready is low under flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_dec     <= '0;
      r_out_field   <= '0;
      r_out_imm     <= '0;
      r_out_has_imm <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_load) begin
        r_out_dec     <= w_ld_dec;
        r_out_field   <= w_ld_field;
        r_out_imm     <= w_ld_imm;
        r_out_has_imm <= w_ld_has;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_out_fire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_dec     = r_out_dec;
  assign out_field   = r_out_field;
  assign out_imm     = r_out_imm;
  assign out_has_imm = r_out_has_imm;
  assign instr_cnt   = r_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: two instances (NOOP kept / NOOP dropped) driven
// together, checked against a byte-stream reference model and a directed table.
module tb_instr_decode_stage;

  localparam int unsigned IMM_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, out_ready, flush;
  logic [7:0] in_data;

  logic        o_rdy [2];
  logic        o_ov  [2];
  logic        o_has [2];
  logic [22:0] o_dec [2];
  logic [3:0]  o_fld [2];
  logic [15:0] o_imm [2];
  logic [3:0]  o_cnt [2];

  instr_decode_stage #(.IMM_BYTES(2), .DROP_NOOP(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(o_rdy[0]), .flush(flush), .out_valid(o_ov[0]), .out_ready(out_ready),
    .out_dec(o_dec[0]), .out_field(o_fld[0]), .out_imm(o_imm[0]),
    .out_has_imm(o_has[0]), .instr_cnt(o_cnt[0]));

  instr_decode_stage #(.IMM_BYTES(2), .DROP_NOOP(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(o_rdy[1]), .flush(flush), .out_valid(o_ov[1]), .out_ready(out_ready),
    .out_dec(o_dec[1]), .out_field(o_fld[1]), .out_imm(o_imm[1]),
    .out_has_imm(o_has[1]), .instr_cnt(o_cnt[1]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
  endtask

  // Reference model: one pending record slot per instance, fed with accepted bytes.
  bit          m_has [2];
  int          m_idx [2];
  int unsigned m_fld [2];
  int unsigned m_imm [2];
  bit          m_hi  [2];
  int unsigned m_cnt [2];
  bit          m_in  [2];
  int unsigned m_opc [2];
  int unsigned m_pn  [2];
  int unsigned m_acc [2];

  function automatic int ref_idx(input int unsigned b);
    int base [16];
    int hi, idx;
    base = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
    hi  = int'(b / 16);
    idx = base[hi];
    if (hi == 1 || hi == 15) idx += int'(b % 4);
    if (hi == 12) idx += int'(b % 2);
    return idx;
  endfunction

  function automatic bit ref_isimm(input int unsigned hi);
    return hi == 3 || hi == 5 || hi == 7 || hi == 14 || hi == 15;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_has[d] = 0; m_idx[d] = 0; m_fld[d] = 0; m_imm[d] = 0; m_hi[d] = 0;
      m_cnt[d] = 0; m_in[d] = 0; m_opc[d] = 0; m_pn[d] = 0; m_acc[d] = 0;
    end
  endtask

  task automatic emit(input int d, input int unsigned opc, input int unsigned imm, input bit has);
    m_has[d] = 1;
    m_idx[d] = ref_idx(opc);
    m_fld[d] = opc % 16;
    m_imm[d] = imm;
    m_hi[d]  = has;
  endtask

  task automatic byte_in(input int d, input int unsigned b);
    if (!m_in[d]) begin
      if (ref_isimm(b / 16)) begin
        m_in[d] = 1; m_opc[d] = b; m_pn[d] = 0; m_acc[d] = 0;
      end else if (!(d == 1 && b / 16 == 0)) begin
        emit(d, b, 0, 0);
      end
    end else begin
      m_acc[d] += b << (8 * m_pn[d]);
      m_pn[d]++;
      if (m_pn[d] == IMM_B) begin
        emit(d, m_opc[d], m_acc[d], 1);
        m_in[d] = 0;
      end
    end
  endtask

  function automatic bit exp_ready(input int d);
    return rst_n && !flush && (!m_has[d] || out_ready);
  endfunction

  task automatic model_edge(input int d);
    bit rdy, take;
    rdy  = exp_ready(d);
    take = m_has[d] && out_ready;
    if (take) m_cnt[d]++;
    if (flush) begin
      m_has[d] = 0; m_in[d] = 0; m_pn[d] = 0;
    end else begin
      if (take) m_has[d] = 0;
      if (in_valid && rdy) byte_in(d, int'(in_data));
    end
  endtask

  task automatic model_check(input int d);
    chk($sformatf("m%0d.in_ready", d), 64'(o_rdy[d]), 64'(exp_ready(d)));
    chk($sformatf("m%0d.out_valid", d), 64'(o_ov[d]), 64'(m_has[d]));
    if (m_has[d]) begin
      chk($sformatf("m%0d.out_dec", d), 64'(o_dec[d]), 64'(23'(1) << m_idx[d]));
      chk($sformatf("m%0d.out_field", d), 64'(o_fld[d]), 64'(m_fld[d]));
      chk($sformatf("m%0d.out_imm", d), 64'(o_imm[d]), 64'(m_imm[d]));
      chk($sformatf("m%0d.out_has_imm", d), 64'(o_has[d]), 64'(m_hi[d]));
    end
    chk($sformatf("m%0d.instr_cnt", d), 64'(o_cnt[d]), 64'(m_cnt[d] % 16));
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic r, input logic f);
    @(negedge clk);
    in_data = d; in_valid = v; out_ready = r; flush = f;
    #1;
    model_check(0);
    model_check(1);
  endtask

  task automatic edge_upd();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
  endtask

  task automatic cycle(input logic [7:0] d, input logic v, input logic r, input logic f);
    step(d, v, r, f);
    edge_upd();
  endtask

  task automatic check_zeros(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s%0d.in_ready", tag, d), 64'(o_rdy[d]), 64'(0));
      chk($sformatf("%s%0d.out_valid", tag, d), 64'(o_ov[d]), 64'(0));
      chk($sformatf("%s%0d.out_dec", tag, d), 64'(o_dec[d]), 64'(0));
      chk($sformatf("%s%0d.out_field", tag, d), 64'(o_fld[d]), 64'(0));
      chk($sformatf("%s%0d.out_imm", tag, d), 64'(o_imm[d]), 64'(0));
      chk($sformatf("%s%0d.out_has_imm", tag, d), 64'(o_has[d]), 64'(0));
      chk($sformatf("%s%0d.instr_cnt", tag, d), 64'(o_cnt[d]), 64'(0));
    end
  endtask

  // Reset asserted between clock edges so the clear is seen without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1;
    check_zeros(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        v, r, f;
    logic        e_rdy, e_ov;
    int          e_idx;
    logic [3:0]  e_fld;
    logic [15:0] e_imm;
    logic        e_has;
    int          e_cnt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{8'h2B, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 0};
    tbl[1]  = '{8'h4F, 1, 1, 0, 1, 1,  5, 4'hB, 16'h0000, 0, 0};
    tbl[2]  = '{8'hC1, 1, 1, 0, 1, 1,  7, 4'hF, 16'h0000, 0, 1};
    tbl[3]  = '{8'h00, 0, 1, 0, 1, 1, 16, 4'h1, 16'h0000, 0, 2};
    tbl[4]  = '{8'hE0, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 3};
    tbl[5]  = '{8'h34, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 3};
    tbl[6]  = '{8'h12, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 3};
    tbl[7]  = '{8'h13, 1, 1, 0, 1, 1, 18, 4'h0, 16'h1234, 1, 3};
    tbl[8]  = '{8'h50, 1, 0, 0, 0, 1,  4, 4'h3, 16'h0000, 0, 4};
    tbl[9]  = '{8'h50, 1, 0, 0, 0, 1,  4, 4'h3, 16'h0000, 0, 4};
    tbl[10] = '{8'h50, 1, 1, 0, 1, 1,  4, 4'h3, 16'h0000, 0, 4};
    tbl[11] = '{8'h11, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 5};
    tbl[12] = '{8'h22, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 5};
    tbl[13] = '{8'h70, 1, 1, 0, 1, 1,  8, 4'h0, 16'h2211, 1, 5};
    tbl[14] = '{8'h60, 1, 1, 1, 0, 0,  0, 4'h0, 16'h0000, 0, 6};
    tbl[15] = '{8'h60, 1, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 6};
    tbl[16] = '{8'h00, 0, 1, 0, 1, 1,  9, 4'h0, 16'h0000, 0, 6};
    tbl[17] = '{8'h00, 0, 1, 0, 1, 0,  0, 4'h0, 16'h0000, 0, 7};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zeros("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].d, tbl[i].v, tbl[i].r, tbl[i].f);
      chk($sformatf("row%0d.in_ready", i), 64'(o_rdy[0]), 64'(tbl[i].e_rdy));
      chk($sformatf("row%0d.out_valid", i), 64'(o_ov[0]), 64'(tbl[i].e_ov));
      chk($sformatf("row%0d.instr_cnt", i), 64'(o_cnt[0]), 64'(tbl[i].e_cnt));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d.out_dec", i), 64'(o_dec[0]), 64'(23'(1) << tbl[i].e_idx));
        chk($sformatf("row%0d.out_field", i), 64'(o_fld[0]), 64'(tbl[i].e_fld));
        chk($sformatf("row%0d.out_imm", i), 64'(o_imm[0]), 64'(tbl[i].e_imm));
        chk($sformatf("row%0d.out_has_imm", i), 64'(o_has[0]), 64'(tbl[i].e_has));
      end
      edge_upd();
    end

    // Reset in the middle of an immediate, then NOOP squash on the fresh stream.
    cycle(8'hE0, 1, 1, 0);
    cycle(8'h34, 1, 1, 0);
    async_reset("areset");
    cycle(8'h00, 1, 1, 0);
    cycle(8'h0F, 1, 1, 0);
    cycle(8'hF2, 1, 1, 0);
    cycle(8'hAA, 1, 1, 0);
    cycle(8'hBB, 1, 1, 0);
    step(8'h00, 0, 1, 0);
    chk("drop.dut1_dec", 64'(o_dec[1]), 64'(23'h200000));
    chk("drop.dut1_imm", 64'(o_imm[1]), 64'(16'hBBAA));
    chk("drop.dut1_cnt", 64'(o_cnt[1]), 64'(0));
    chk("drop.dut0_dec", 64'(o_dec[0]), 64'(23'h200000));
    chk("drop.dut0_cnt", 64'(o_cnt[0]), 64'(2));
    edge_upd();
    step(8'h00, 0, 1, 0);
    chk("drop.dut1_cnt_end", 64'(o_cnt[1]), 64'(1));
    chk("drop.dut0_cnt_end", 64'(o_cnt[0]), 64'(3));
    edge_upd();

    // Counter wrap with a 4-bit counter: 17 records.
    async_reset("wreset");
    for (int i = 0; i < 17; i++) cycle(8'h20, 1, 1, 0);
    step(8'h00, 0, 1, 0);
    chk("wrap.cnt16", 64'(o_cnt[0]), 64'(0));
    edge_upd();
    step(8'h00, 0, 1, 0);
    chk("wrap.dut0_cnt17", 64'(o_cnt[0]), 64'(1));
    chk("wrap.dut1_cnt17", 64'(o_cnt[1]), 64'(1));
    edge_upd();

    for (int i = 0; i < 1500; i++) begin
      cycle(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, handshaked instruction-decode stage fed by the program-memory byte stream. It assembles each instruction from its opcode byte plus 0..IMM_BYTES immediate bytes and emits one decoded record per instruction to the execute controller. The record carries the 23-line one-hot decode, the low-nibble operand field and the assembled immediate. It is the pipelined successor of the combinational opcode decoder: width-parametrised immediates, optional NOOP squash, flush and an emitted-instruction counter.

## Interface
- IMM_BYTES, 1: immediate bytes following an immediate-class opcode; legal 1..4; IMM_W = 8*IMM_BYTES
- DROP_NOOP, 0: 1 = NOOP opcodes (upper nibble 0000) are consumed without emitting a record
- CNT_W, 16: width of the emitted-instruction counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  8  byte from program memory
- in_valid  in  1  in_data valid
- in_ready  out  1  stage accepts in_data this cycle
- flush  in  1  synchronous; abandon partial instruction and drop held record
- out_valid  out  1  decoded record valid
- out_ready  in  1  consumer takes record this cycle
- out_dec  out  23  one-hot decode, bit map below
- out_field  out  4  opcode[3:0], natural bit order (out_field[0] = opcode[0])
- out_imm  out  IMM_W  assembled immediate; 0 for non-immediate instructions
- out_has_imm  out  1  record carries an immediate
- instr_cnt  out  CNT_W  records emitted (handshakes completed), wraps

## Operation
- Byte transfer when in_valid && in_ready; record transfer when out_valid && out_ready.
- in_ready = rst_n && !flush && (!out_valid || out_ready), in both states.
- Decode of opcode[7:4]: 0000 NOOP→0; 0001 INPUT group→1+opcode[1:0] (bits 1..4); 0010 MOVE→5; 0011 LOADI/LOADP→6; 0100 ADD→7; 0101 ADDI→8; 0110 SUB→9; 0111 SUBI→10; 1000 LOAD→11; 1001 LOADF→12; 1010 STORE→13; 1011 STOREF→14; 1100 SHIFT→15+opcode[0]; 1101 CMP→17; 1110 JUMP→18; 1111 branch→19+opcode[1:0] (bits 19..22). Exactly one out_dec bit set whenever out_valid.
- Immediate class: upper nibble 0011, 0101, 0111, 1110, 1111.
- States: S_OPC (expect opcode), S_IMM (collecting immediate).
- S_OPC, opcode accepted: non-immediate → load output register (out_has_imm=0, out_imm=0) and stay in S_OPC; immediate class → latch decode/field, clear byte counter, go to S_IMM. DROP_NOOP=1 and NOOP → no record, stay in S_OPC.
- S_IMM: each accepted byte written to out_imm byte lane [8*k+7:8*k], k = byte counter (little-endian, first byte = LSB). On byte k = IMM_BYTES-1, load output register (out_has_imm=1), return to S_OPC.
- Output register updates only when empty or being drained the same cycle (guaranteed by in_ready). out_dec/out_field/out_imm hold stable while out_valid && !out_ready.
- flush (priority over all): out_valid→0, state→S_OPC, byte counter→0, no byte accepted that cycle. instr_cnt unaffected. A record handshaking in the flush cycle still counts.
- instr_cnt increments by 1 per record transfer, wraps 2^CNT_W-1→0.

## Timing
- Reset (rst_n low, async): state S_OPC, out_valid 0, out_dec 0, out_field 0, out_imm 0, out_has_imm 0, instr_cnt 0, byte counter 0, in_ready 0.
- Latency: final byte of an instruction accepted at edge N → out_valid high after edge N (visible cycle N+1).
- Throughput: one single-byte instruction per cycle with out_ready held high; an immediate instruction takes 1+IMM_BYTES accepted bytes.
- Back-pressure: out_valid && !out_ready → in_ready 0; no byte is lost or accepted.
- in_valid low in S_IMM: stage waits indefinitely and keeps its partial state.
- Reset asserted mid-instruction discards the partial instruction; the first byte after reset is treated as an opcode.
- Simultaneous record drain and new completion in one cycle: new record loaded, out_valid stays 1, instr_cnt +1.

## Test plan
- Reset, then stream 0x2B, 0x4F, 0xC1 with out_ready=1 → three consecutive records: dec bit 5 field 0xB; bit 7 field 0xF; bit 16 field 0x1. out_has_imm=0, instr_cnt=3.
- IMM_BYTES=2: stream 0xE0, 0x34, 0x12 → one record, dec bit 18, out_imm=0x1234, out_has_imm=1, 1 cycle after byte 0x12.
- Hold out_ready=0 after 0x13 emitted, offer 0x50 → in_ready=0 and record (bit 4, field 0x3) stable; release out_ready → 0x50 accepted next cycle.
- DROP_NOOP=1: stream 0x00, 0x0F, 0xF2, 0xAA → single record, dec bit 21, out_imm=0xAA, instr_cnt=1; with DROP_NOOP=0 the same stream gives two NOOP records first.
- Flush after 0x70 (mid-SUBI) → state S_OPC; next 0x60 yields dec bit 9, out_has_imm=0; no SUBI record ever emitted.
- CNT_W=4: emit 17 records → instr_cnt wraps to 1. Async reset mid-S_IMM → all outputs 0 immediately.
